// File: rtl/bird_pkg.sv
// Shared constants and types for the bird collision detector.
package bird_pkg;

  // Object geometry: the bird sprite is an 8x8 grid of 8-pixel cells.
  localparam int unsigned OBJ_WIDTH  = 64;
  localparam int unsigned OBJ_HEIGHT = 64;

  // Datapath widths.
  localparam int unsigned POS_W  = 11;
  localparam int unsigned OFF_W  = 12;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = 4;

  // Edge codes: bit3=left, bit2=top, bit1=right, bit0=bottom.
  localparam logic [CODE_W-1:0] EDGE_NONE         = 4'h0;
  localparam logic [CODE_W-1:0] EDGE_BOTTOM       = 4'h1;
  localparam logic [CODE_W-1:0] EDGE_RIGHT        = 4'h2;
  localparam logic [CODE_W-1:0] EDGE_BOTTOM_RIGHT = 4'h3;
  localparam logic [CODE_W-1:0] EDGE_TOP          = 4'h4;
  localparam logic [CODE_W-1:0] EDGE_TOP_RIGHT    = 4'h6;
  localparam logic [CODE_W-1:0] EDGE_LEFT         = 4'h8;
  localparam logic [CODE_W-1:0] EDGE_BOTTOM_LEFT  = 4'h9;
  localparam logic [CODE_W-1:0] EDGE_TOP_LEFT     = 4'hC;

  // Per-frame hit emission state.
  typedef enum logic [1:0] {
    IDLE_ST      = 2'd0,
    SCAN_ST      = 2'd1,
    SATURATED_ST = 2'd2
  } bird_state_e;

endpackage : bird_pkg

// File: rtl/bird_edge_lut.sv
// Maps the hit cell (row r, column c) of the 8x8 bird grid to an edge code.
// The diagonals mark corners; the four triangles between them mark sides.
module bird_edge_lut
  import bird_pkg::*;
(
  input  logic [2:0]        r,
  input  logic [2:0]        c,
  output logic [CODE_W-1:0] code
);

  logic [3:0] sum_c;

  // Classify the cell against the main and anti diagonals.
  always_comb begin
    sum_c = {1'b0, r} + {1'b0, c};
    code  = EDGE_NONE;
    if (r == c) begin
      code = (r <= 3'd3) ? EDGE_TOP_LEFT : EDGE_BOTTOM_RIGHT;
    end else if (sum_c == 4'd7) begin
      code = (r <= 3'd3) ? EDGE_TOP_RIGHT : EDGE_BOTTOM_LEFT;
    end else if (sum_c < 4'd7) begin
      code = (r < c) ? EDGE_TOP : EDGE_LEFT;
    end else begin
      code = (r > c) ? EDGE_BOTTOM : EDGE_RIGHT;
    end
  end

endmodule : bird_edge_lut

// File: rtl/bird_hit_detector.sv
// Bird/obstacle collision detector with edge classification.
// Two-stage pipeline: stage 1 registers the pixel offset inside the bird box,
// stage 2 emits a one-clock collision pulse with its edge code.
// A per-frame FSM caps the number of pulses per frame.
// Optional macro BIRD_HIT_SUMMARY_EN enables the previous-frame summary
// outputs (frameHitCount, firstHitCode, firstHitValid); otherwise they are 0.
module bird_hit_detector
  import bird_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X     = OBJ_WIDTH,
  parameter int unsigned OBJECT_HIGHT_Y     = OBJ_HEIGHT,
  parameter int unsigned MAX_HITS_PER_FRAME = 255
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [POS_W-1:0]        pixelX,
  input  logic [POS_W-1:0]        pixelY,
  input  logic signed [POS_W-1:0] birdTopLeftX,
  input  logic signed [POS_W-1:0] birdTopLeftY,
  input  logic                    birdDrawingRequest,
  input  logic                    obstacleDrawingRequest,
  output logic                    collision,
  output logic [CODE_W-1:0]       HitEdgeCode,
  output logic [CNT_W-1:0]        frameHitCount,
  output logic [CODE_W-1:0]       firstHitCode,
  output logic                    firstHitValid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HITS_PER_FRAME);

  // Stage 1 signals.
  logic signed [OFF_W-1:0] off_x_d, off_x_q;
  logic signed [OFF_W-1:0] off_y_d, off_y_q;
  logic                    in_x_c, in_y_c;
  logic                    hit1_d, hit1_q;

  // Stage 2 / FSM signals.
  bird_state_e             state_d, state_q;
  logic [CNT_W-1:0]        hit_cnt_d, hit_cnt_q;
  logic [CNT_W-1:0]        cnt_inc_c;
  logic                    collision_d, collision_q;
  logic [CODE_W-1:0]       edge_d, edge_q;
  logic [CODE_W-1:0]       lut_code_c;

  // Only the cell-index bits of the offsets feed the edge LUT.
  logic unused_off_bits;
  assign unused_off_bits = ^{off_x_q[OFF_W-1:6], off_x_q[2:0],
                             off_y_q[OFF_W-1:6], off_y_q[2:0]};

  // Offset of the scan pixel from the bird corner, and the in-box overlap test.
  always_comb begin
    off_x_d = {1'b0, pixelX} - {birdTopLeftX[POS_W-1], birdTopLeftX};
    off_y_d = {1'b0, pixelY} - {birdTopLeftY[POS_W-1], birdTopLeftY};
    in_x_c  = !off_x_d[OFF_W-1] && (off_x_d[OFF_W-2:0] < POS_W'(OBJECT_WIDTH_X));
    in_y_c  = !off_y_d[OFF_W-1] && (off_y_d[OFF_W-2:0] < POS_W'(OBJECT_HIGHT_Y));
    hit1_d  = birdDrawingRequest && obstacleDrawingRequest && in_x_c && in_y_c;
  end

  // Stage 1 register; a frame start flushes the hit in this stage.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      off_x_q <= '0;
      off_y_q <= '0;
      hit1_q  <= 1'b0;
    end else begin
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
      hit1_q  <= startOfFrame ? 1'b0 : hit1_d;
    end
  end

  bird_edge_lut u_edge_lut (
    .r    (off_y_q[5:3]),
    .c    (off_x_q[5:3]),
    .code (lut_code_c)
  );

  assign cnt_inc_c = hit_cnt_q + CNT_W'(1);

  // Frame FSM: gates stage-2 pulses, counts them and saturates at the cap.
  always_comb begin
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    collision_d = 1'b0;
    unique case (state_q)
      IDLE_ST: begin
        if (startOfFrame) begin
          state_d   = SCAN_ST;
          hit_cnt_d = '0;
        end
      end
      SCAN_ST: begin
        if (startOfFrame) begin
          hit_cnt_d = '0;
        end else if (hit1_q) begin
          collision_d = 1'b1;
          hit_cnt_d   = cnt_inc_c;
          if (cnt_inc_c >= MAX_CNT) begin
            state_d = SATURATED_ST;
          end
        end
      end
      SATURATED_ST: begin
        if (startOfFrame) begin
          state_d   = SCAN_ST;
          hit_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE_ST;
        hit_cnt_d = '0;
      end
    endcase
    edge_d = collision_d ? lut_code_c : EDGE_NONE;
  end

  // Stage 2 and FSM registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE_ST;
      hit_cnt_q   <= '0;
      collision_q <= 1'b0;
      edge_q      <= EDGE_NONE;
    end else begin
      state_q     <= state_d;
      hit_cnt_q   <= hit_cnt_d;
      collision_q <= collision_d;
      edge_q      <= edge_d;
    end
  end

  assign collision   = collision_q;
  assign HitEdgeCode = edge_q;

`ifdef BIRD_HIT_SUMMARY_EN
  logic [CODE_W-1:0] cur_first_code_q;
  logic              cur_first_valid_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic [CODE_W-1:0] first_code_q;
  logic              first_valid_q;

  // Capture the first emitted pulse of the running frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_first_code_q  <= EDGE_NONE;
      cur_first_valid_q <= 1'b0;
    end else if (startOfFrame) begin
      cur_first_code_q  <= EDGE_NONE;
      cur_first_valid_q <= 1'b0;
    end else if (collision_d && !cur_first_valid_q) begin
      cur_first_code_q  <= edge_d;
      cur_first_valid_q <= 1'b1;
    end
  end

  // Publish the ending frame's totals at each frame start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q   <= '0;
      first_code_q  <= EDGE_NONE;
      first_valid_q <= 1'b0;
    end else if (startOfFrame) begin
      frame_cnt_q   <= hit_cnt_q;
      first_code_q  <= cur_first_code_q;
      first_valid_q <= cur_first_valid_q;
    end
  end

  assign frameHitCount = frame_cnt_q;
  assign firstHitCode  = first_code_q;
  assign firstHitValid = first_valid_q;
`else
  assign frameHitCount = '0;
  assign firstHitCode  = EDGE_NONE;
  assign firstHitValid = 1'b0;
`endif

endmodule : bird_hit_detector

// File: tb/tb_bird_hit_detector.sv
// Directed bench for bird_hit_detector (cap of 3 hits per frame).
module tb_bird_hit_detector;

`ifdef BIRD_HIT_SUMMARY_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic signed [10:0] birdTopLeftX, birdTopLeftY;
  logic        birdDrawingRequest, obstacleDrawingRequest;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [7:0]  frameHitCount;
  logic [3:0]  firstHitCode;
  logic        firstHitValid;

  int n_tests = 0;
  int n_fail  = 0;

  bird_hit_detector #(
    .OBJECT_WIDTH_X     (64),
    .OBJECT_HIGHT_Y     (64),
    .MAX_HITS_PER_FRAME (3)
  ) dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (startOfFrame),
    .pixelX                 (pixelX),
    .pixelY                 (pixelY),
    .birdTopLeftX           (birdTopLeftX),
    .birdTopLeftY           (birdTopLeftY),
    .birdDrawingRequest     (birdDrawingRequest),
    .obstacleDrawingRequest (obstacleDrawingRequest),
    .collision              (collision),
    .HitEdgeCode            (HitEdgeCode),
    .frameHitCount          (frameHitCount),
    .firstHitCode           (firstHitCode),
    .firstHitValid          (firstHitValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sum_exp(input int v);
    return SUM_EN ? v : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input bit breq, input bit oreq);
    pixelX                 = 11'(x);
    pixelY                 = 11'(y);
    birdDrawingRequest     = breq;
    obstacleDrawingRequest = oreq;
  endtask

  task automatic set_bird(input int x, input int y);
    birdTopLeftX = 11'(x);
    birdTopLeftY = 11'(y);
  endtask

  task automatic sof();
    drive_px(0, 0, 1'b0, 1'b0);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  // One pixel for one clock, then check the pulse two clocks after it.
  task automatic probe(input string tag, input int x, input int y, input bit breq,
                       input bit oreq, input int exp_col, input int exp_code);
    drive_px(x, y, breq, oreq);
    step();
    drive_px(0, 0, 1'b0, 1'b0);
    step();
    check({tag, "_col"}, int'(collision), exp_col);
    check({tag, "_code"}, int'(HitEdgeCode), exp_code);
  endtask

  task automatic check_summary(input string tag, input int cnt, input int code, input int vld);
    check({tag, "_cnt"}, int'(frameHitCount), sum_exp(cnt));
    check({tag, "_code"}, int'(firstHitCode), sum_exp(code));
    check({tag, "_vld"}, int'(firstHitValid), sum_exp(vld));
  endtask

  initial begin
    int px[5];
    int py[5];
    int codes[3];
    int npulse;

    px = '{280, 300, 343, 280, 343};
    py = '{185, 248, 200, 248, 185};
    codes = '{0, 0, 0};

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    drive_px(0, 0, 1'b0, 1'b0);
    set_bird(280, 185);
    step();
    step();
    check("rst_col", int'(collision), 0);
    check("rst_code", int'(HitEdgeCode), 0);
    check_summary("rst_sum", 0, 0, 0);
    resetN = 1'b1;
    step();

    // IDLE after reset: no pulse without a frame start.
    probe("idle", 280, 185, 1'b1, 1'b1, 0, 0);

    // Frame A: corner and side cells, then one-clock pulse width.
    sof();
    probe("tl", 280, 185, 1'b1, 1'b1, 1, 12);
    step();
    check("pulse_w_col", int'(collision), 0);
    check("pulse_w_code", int'(HitEdgeCode), 0);
    probe("bot", 300, 248, 1'b1, 1'b1, 1, 1);
    probe("right", 343, 200, 1'b1, 1'b1, 1, 2);
    sof();
    check_summary("sumA", 3, 12, 1);

    // Frame B: box boundaries and single-request pixels.
    set_bird(-10, 100);
    probe("negx", -12, 100, 1'b1, 1'b1, 0, 0);
    probe("x64", 54, 100, 1'b1, 1'b1, 0, 0);
    probe("negbird_in", 0, 100, 1'b1, 1'b1, 1, 4);
    set_bird(280, 185);
    probe("xm1", 279, 200, 1'b1, 1'b1, 0, 0);
    probe("y64", 290, 249, 1'b1, 1'b1, 0, 0);
    probe("obst_only", 290, 200, 1'b0, 1'b1, 0, 0);
    probe("bird_only", 290, 200, 1'b1, 1'b0, 0, 0);
    probe("bl", 280, 248, 1'b1, 1'b1, 1, 9);
    sof();
    check_summary("sumB", 2, 4, 1);

    // Frame C: five back-to-back hits against a cap of three.
    npulse = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) drive_px(px[k], py[k], 1'b1, 1'b1);
      else       drive_px(0, 0, 1'b0, 1'b0);
      step();
      if (collision) begin
        if (npulse < 3) codes[npulse] = int'(HitEdgeCode);
        npulse++;
      end
    end
    check("sat_pulses", npulse, 3);
    check("sat_code0", codes[0], 12);
    check("sat_code1", codes[1], 1);
    check("sat_code2", codes[2], 2);
    probe("sat_more", 343, 185, 1'b1, 1'b1, 0, 0);
    sof();
    check_summary("sumC", 3, 12, 1);

    // Frame D: one counted hit, then a hit dropped by the frame start.
    probe("d_hit", 343, 185, 1'b1, 1'b1, 1, 6);
    drive_px(343, 200, 1'b1, 1'b1);
    step();
    sof();
    check("drop_col", int'(collision), 0);
    check_summary("sumD", 1, 6, 1);
    step();
    check("drop_col2", int'(collision), 0);

    // Frame E: two hits, then reset while the second pulse is high.
    probe("e_hit1", 280, 185, 1'b1, 1'b1, 1, 12);
    probe("e_hit2", 300, 248, 1'b1, 1'b1, 1, 1);
    #2;
    resetN = 1'b0;
    #1;
    check("mrst_col", int'(collision), 0);
    check("mrst_code", int'(HitEdgeCode), 0);
    check_summary("mrst_sum", 0, 0, 0);
    step();
    resetN = 1'b1;
    step();
    probe("post_rst", 280, 185, 1'b1, 1'b1, 0, 0);
    sof();
    check_summary("sumF", 0, 0, 0);
    probe("f_hit", 280, 185, 1'b1, 1'b1, 1, 12);
    sof();
    check_summary("sumG", 1, 12, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bird_hit_detector

// File: doc/bird_hit_detector.md
BIRD_HIT_DETECTOR -- requirements
Module: bird_hit_detector

Interface
REQ-001 Parameter OBJECT_WIDTH_X, default 64, bird width in pixels; SHALL be 64 (8 cells of 8 px).
REQ-002 Parameter OBJECT_HIGHT_Y, default 64, bird height in pixels; SHALL be 64.
REQ-003 Parameter MAX_HITS_PER_FRAME, default 255, maximum collision pulses emitted per frame, range 1..255.
REQ-004 clk  input  1  the single clock.
REQ-005 resetN  input  1  reset; asynchronous, active-low.
REQ-006 startOfFrame  input  1  one-clock pulse at each frame start.
REQ-007 pixelX, pixelY  input  11 each  current scan pixel.
REQ-008 birdTopLeftX, birdTopLeftY  input  11 signed each  bird top-left corner.
REQ-009 birdDrawingRequest  input  1  bird pixel is opaque at (pixelX,pixelY).
REQ-010 obstacleDrawingRequest  input  1  an obstacle (ground, plane, brackets) is drawn at the same pixel.
REQ-011 collision  output  1  one-clock hit pulse, aligned with HitEdgeCode.
REQ-012 HitEdgeCode  output  4  edge code of the hit; valid only while collision=1, else 0.
REQ-013 frameHitCount  output  8  hits emitted in the previous frame.
REQ-014 firstHitCode  output  4  edge code of the previous frame's first hit.
REQ-015 firstHitValid  output  1  previous frame had at least one hit.

Function
REQ-016 Stage 1 SHALL register offX=pixelX-birdTopLeftX and offY=pixelY-birdTopLeftY in 12-bit signed arithmetic, plus hit1 = birdDrawingRequest & obstacleDrawingRequest & 0<=offX<64 & 0<=offY<64.
REQ-017 Stage 2 SHALL register collision=hit1 (subject to gating) and HitEdgeCode=LUT(r=offY[5:3], c=offX[5:3]); total latency is 2 clocks from pixel inputs.
REQ-018 LUT: r==c,r<=3 -> C; r+c==7,r<=3 -> 6; r+c==7,r>=4 -> 9; r==c,r>=4 -> 3; r<c,r+c<7 -> 4; r>c,r+c<7 -> 8; r>c,r+c>7 -> 1; r<c,r+c>7 -> 2.
REQ-019 States: IDLE_ST (after reset; collision held 0; startOfFrame -> SCAN_ST), SCAN_ST (hits emitted), SATURATED_ST (collision suppressed; startOfFrame -> SCAN_ST).
REQ-020 In SCAN_ST, when the emitted-hit counter reaches MAX_HITS_PER_FRAME, the FSM SHALL move to SATURATED_ST on the same clock as that last pulse.
REQ-021 On startOfFrame in any non-IDLE state: hit counter cleared; both pipeline valid bits cleared; a hit in flight on that clock is dropped and not counted.
REQ-022 On startOfFrame, summary outputs SHALL load the ending frame's counter, first code and first-valid flag, and hold them until the next startOfFrame.
REQ-023 Pixels with offX or offY outside 0..63 SHALL never produce collision, including negative birdTopLeftX/Y.

Reset
REQ-024 resetN=0 SHALL asynchronously force IDLE_ST, pipeline registers 0, collision=0, HitEdgeCode=0, counter 0, frameHitCount=0, firstHitCode=0, firstHitValid=0.
REQ-025 Reset mid-frame SHALL discard all in-flight and accumulated hits; the first pulse after release requires a startOfFrame.

Configuration
REQ-026 Macro BIRD_HIT_SUMMARY_EN defined: frameHitCount, firstHitCode and firstHitValid SHALL behave per REQ-022.
REQ-027 Macro BIRD_HIT_SUMMARY_EN undefined: those three outputs SHALL be constant 0 and the summary registers absent; collision/HitEdgeCode are unchanged.

Structure
REQ-028 Package bird_pkg SHALL hold edge-code constants (EDGE_BOTTOM=1, RIGHT=2, BOTTOM_RIGHT=3, TOP=4, TOP_RIGHT=6, LEFT=8, BOTTOM_LEFT=9, TOP_LEFT=C), object size constants and the FSM state typedef.
REQ-029 Combinational sub-module bird_edge_lut (inputs r,c 3 bits; output code 4 bits) SHALL implement REQ-018.

Verification
REQ-030 Reset, startOfFrame, bird at (280,185), both requests high at pixel (280,185) -> collision=1, HitEdgeCode=C exactly 2 clocks later.
REQ-031 Same bird, hit at pixel (300,248) (r=7,c=2) -> HitEdgeCode=1; pixel (343,200) (r=1,c=7) -> HitEdgeCode=2.
REQ-032 Bird at (-10,100), requests high at pixelX=-12 equivalent (offX<0) and at offX=64 -> no collision.
REQ-033 MAX_HITS_PER_FRAME=3, 5 hit pixels in one frame -> exactly 3 pulses; next startOfFrame -> frameHitCount=3, firstHitCode = first pulse's code, firstHitValid=1.
REQ-034 Hit pixel presented 1 clock before startOfFrame -> no pulse; frameHitCount for that frame excludes it.
REQ-035 resetN asserted mid-frame after 2 hits -> all outputs 0 immediately; no pulse until a startOfFrame.
